// File: rtl/bank_req_arb.sv
// Round-robin front end for a single-ported 16-bit bank shared by three requesters.
// Accepted requests issue one cycle later; reads return through an RD_LAT-deep tag pipeline.
module bank_req_arb #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1,
    parameter bit          WR_ACK = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_wdata,
    input  logic [1:0]        p1_req_tag,
    input  logic              p2_req_valid,
    output logic              p2_req_ready,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [15:0]       p2_wdata,
    input  logic [1:0]        p2_req_tag,
    input  logic              p3_req_valid,
    output logic              p3_req_ready,
    input  logic              p3_we,
    input  logic [ADDR_W-1:0] p3_addr,
    input  logic [15:0]       p3_wdata,
    input  logic [1:0]        p3_req_tag,
    output logic              bank_en,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [15:0]       bank_wdata,
    input  logic [15:0]       bank_rdata,
    output logic              p1_resp_valid,
    output logic [15:0]       p1_resp_data,
    output logic [1:0]        p1_resp_tag,
    output logic              p2_resp_valid,
    output logic [15:0]       p2_resp_data,
    output logic [1:0]        p2_resp_tag,
    output logic              p3_resp_valid,
    output logic [15:0]       p3_resp_data,
    output logic [1:0]        p3_resp_tag
);

    typedef enum logic [1:0] {
        PTR_P1 = 2'd0,
        PTR_P2 = 2'd1,
        PTR_P3 = 2'd2
    } ptr_e;

    typedef struct packed {
        logic       vld;
        logic       rd;
        logic [1:0] port;
        logic [1:0] tag;
    } pipe_ent_t;

    ptr_e ptr_q, ptr_d;

    logic [2:0]        req_valid;
    logic [2:0]        req_we;
    logic [ADDR_W-1:0] req_addr  [3];
    logic [15:0]       req_wdata [3];
    logic [1:0]        req_tag   [3];

    logic [2:0] gnt_oh;
    logic [1:0] gnt_idx;
    logic       gnt_any;
    logic [2:0] cand;
    logic       accept;

    logic              bank_en_q, bank_we_q;
    logic [ADDR_W-1:0] bank_addr_q;
    logic [15:0]       bank_wdata_q;
    logic [1:0]        iss_port_q, iss_tag_q;

    pipe_ent_t pipe_q [RD_LAT];
    pipe_ent_t push_ent, exit_ent;

    logic [2:0]  resp_valid_q;
    logic [15:0] resp_data_q [3];
    logic [1:0]  resp_tag_q  [3];

    assign req_valid = {p3_req_valid, p2_req_valid, p1_req_valid};
    assign req_we    = {p3_we, p2_we, p1_we};
    assign req_addr  = '{p1_addr, p2_addr, p3_addr};
    assign req_wdata = '{p1_wdata, p2_wdata, p3_wdata};
    assign req_tag   = '{p1_req_tag, p2_req_tag, p3_req_tag};

    // Scan from the pointer, wrapping port 3 back to port 1; first valid port wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!gnt_any && req_valid[cand[1:0]]) begin
                gnt_any          = 1'b1;
                gnt_idx          = cand[1:0];
                gnt_oh[cand[1:0]] = 1'b1;
            end
        end
    end

    assign accept       = gnt_any & ~rst;
    assign p1_req_ready = gnt_oh[0] & ~rst;
    assign p2_req_ready = gnt_oh[1] & ~rst;
    assign p3_req_ready = gnt_oh[2] & ~rst;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            case (gnt_idx)
                2'd0:    ptr_d = PTR_P2;
                2'd1:    ptr_d = PTR_P3;
                default: ptr_d = PTR_P1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= PTR_P1;
        else     ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_en_q    <= 1'b0;
            bank_we_q    <= 1'b0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            iss_port_q   <= '0;
            iss_tag_q    <= '0;
        end else begin
            bank_en_q <= accept;
            bank_we_q <= accept & req_we[gnt_idx];
            if (accept) begin
                bank_addr_q  <= req_addr[gnt_idx];
                bank_wdata_q <= req_wdata[gnt_idx];
                iss_port_q   <= gnt_idx;
                iss_tag_q    <= req_tag[gnt_idx];
            end
        end
    end

    assign bank_en    = bank_en_q;
    assign bank_we    = bank_we_q;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;

    // Silent writes still occupy a slot so read order and latency stay fixed.
    always_comb begin
        push_ent      = '0;
        push_ent.vld  = bank_en_q & (~bank_we_q | WR_ACK);
        push_ent.rd   = ~bank_we_q;
        push_ent.port = iss_port_q;
        push_ent.tag  = iss_tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < RD_LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= push_ent;
            for (int unsigned k = 1; k < RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign exit_ent = pipe_q[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            for (int unsigned p = 0; p < 3; p++) begin
                resp_data_q[p] <= '0;
                resp_tag_q[p]  <= '0;
            end
        end else begin
            resp_valid_q <= '0;
            if (exit_ent.vld) begin
                resp_valid_q[exit_ent.port] <= 1'b1;
                resp_data_q[exit_ent.port]  <= exit_ent.rd ? bank_rdata : 16'h0000;
                resp_tag_q[exit_ent.port]   <= exit_ent.tag;
            end
        end
    end

    assign p1_resp_valid = resp_valid_q[0];
    assign p2_resp_valid = resp_valid_q[1];
    assign p3_resp_valid = resp_valid_q[2];
    assign p1_resp_data  = resp_data_q[0];
    assign p2_resp_data  = resp_data_q[1];
    assign p3_resp_data  = resp_data_q[2];
    assign p1_resp_tag   = resp_tag_q[0];
    assign p2_resp_tag   = resp_tag_q[1];
    assign p3_resp_tag   = resp_tag_q[2];

endmodule

// File: tb/tb_bank_req_arb.sv
// Scoreboard bench: two instances (RD_LAT=1/WR_ACK=0 and RD_LAT=3/WR_ACK=1) share one stimulus stream,
// each with its own behavioural bank; expected grants, issues and responses come from a cycle model.
module tb_bank_req_arb;

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [15:0] wd;
        logic [1:0] t;
    } req_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [7:0]  a;
        logic [15:0] wd;
    } iss_t;

    typedef struct {
        int          due;
        int          port;
        logic [15:0] data;
        logic [1:0]  tag;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  vld, we;
    logic [7:0]  addr  [3];
    logic [15:0] wdata [3];
    logic [1:0]  tag   [3];

    wire [2:0]  rdy_w    [2];
    wire        en_w     [2];
    wire        we_w     [2];
    wire [7:0]  baddr_w  [2];
    wire [15:0] bwdata_w [2];
    wire [15:0] brdata_w [2];
    wire [2:0]  rv_w     [2];
    wire [15:0] rdat_w   [2][3];
    wire [1:0]  rtag_w   [2][3];

    int n_checks, n_fail, cyc, ptr_m;
    logic [2:0]  acc;
    logic [15:0] mmem [256];
    req_t req_q [3][$];
    iss_t iss_q [$];
    rsp_t rsp_q [2][$];

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int LAT = (d == 0) ? 1 : 3;
        localparam bit ACK = (d == 0) ? 1'b0 : 1'b1;
        logic [15:0] mem   [256];
        logic [15:0] rpipe [LAT];

        bank_req_arb #(.ADDR_W(8), .RD_LAT(LAT), .WR_ACK(ACK)) u_dut (
            .clk(clk), .rst(rst),
            .p1_req_valid(vld[0]), .p1_req_ready(rdy_w[d][0]), .p1_we(we[0]),
            .p1_addr(addr[0]), .p1_wdata(wdata[0]), .p1_req_tag(tag[0]),
            .p2_req_valid(vld[1]), .p2_req_ready(rdy_w[d][1]), .p2_we(we[1]),
            .p2_addr(addr[1]), .p2_wdata(wdata[1]), .p2_req_tag(tag[1]),
            .p3_req_valid(vld[2]), .p3_req_ready(rdy_w[d][2]), .p3_we(we[2]),
            .p3_addr(addr[2]), .p3_wdata(wdata[2]), .p3_req_tag(tag[2]),
            .bank_en(en_w[d]), .bank_we(we_w[d]), .bank_addr(baddr_w[d]),
            .bank_wdata(bwdata_w[d]), .bank_rdata(brdata_w[d]),
            .p1_resp_valid(rv_w[d][0]), .p1_resp_data(rdat_w[d][0]), .p1_resp_tag(rtag_w[d][0]),
            .p2_resp_valid(rv_w[d][1]), .p2_resp_data(rdat_w[d][1]), .p2_resp_tag(rtag_w[d][1]),
            .p3_resp_valid(rv_w[d][2]), .p3_resp_data(rdat_w[d][2]), .p3_resp_tag(rtag_w[d][2])
        );

        initial for (int i = 0; i < 256; i++) mem[i] <= init_word(i);

        always @(posedge clk) begin
            if (en_w[d] && we_w[d]) mem[baddr_w[d]] <= bwdata_w[d];
            rpipe[0] <= mem[baddr_w[d]];
            for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
        end

        assign brdata_w[d] = rpipe[LAT-1];
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_req(input int p, input logic w, input logic [7:0] a,
                            input logic [15:0] d, input logic [1:0] t);
        req_t r;
        r.we = w; r.a = a; r.wd = d; r.t = t;
        req_q[p].push_back(r);
    endtask

    task automatic wait_drain();
        int pending;
        pending = 1;
        for (int i = 0; i < 300 && pending != 0; i++) begin
            @(posedge clk);
            #2;
            pending = req_q[0].size() + req_q[1].size() + req_q[2].size()
                    + iss_q.size() + rsp_q[0].size() + rsp_q[1].size();
        end
        if (pending != 0) check_eq("drain_timeout", 32'(pending), 32'd0);
    endtask

    // Requesters hold their head request until the model says it was accepted.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 3; p++) begin
            if (acc[p]) begin
                void'(req_q[p].pop_front());
                acc[p] = 1'b0;
            end
            if (req_q[p].size() > 0) begin
                vld[p]   = 1'b1;
                we[p]    = req_q[p][0].we;
                addr[p]  = req_q[p][0].a;
                wdata[p] = req_q[p][0].wd;
                tag[p]   = req_q[p][0].t;
            end else begin
                vld[p] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int   g, p;
        logic [2:0] er;
        req_t r;
        iss_t is;
        rsp_t rs;
        if (rst) begin
            iss_q.delete();
            rsp_q[0].delete();
            rsp_q[1].delete();
            ptr_m = 0;
            acc   = '0;
            for (int d = 0; d < 2; d++) check_eq("ready_in_reset", 32'(rdy_w[d]), 32'd0);
        end else begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (ptr_m + k) % 3;
                if (g < 0 && vld[c]) g = c;
            end
            er = (g >= 0) ? 3'(1 << g) : 3'b000;
            for (int d = 0; d < 2; d++) begin
                check_eq("ready", 32'(rdy_w[d]), 32'(er));
                if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                    check_eq("bank_en", 32'(en_w[d]), 32'd1);
                    check_eq("bank_we", 32'(we_w[d]), 32'(iss_q[0].we));
                    check_eq("bank_addr", 32'(baddr_w[d]), 32'(iss_q[0].a));
                    if (iss_q[0].we) check_eq("bank_wdata", 32'(bwdata_w[d]), 32'(iss_q[0].wd));
                end else begin
                    check_eq("bank_en_idle", 32'(en_w[d]), 32'd0);
                    check_eq("bank_we_idle", 32'(we_w[d]), 32'd0);
                end
                if (rsp_q[d].size() > 0 && rsp_q[d][0].due == cyc) begin
                    rs = rsp_q[d].pop_front();
                    p  = rs.port;
                    check_eq("resp_valid", 32'(rv_w[d]), 32'(1 << p));
                    check_eq("resp_data", 32'(rdat_w[d][p]), 32'(rs.data));
                    check_eq("resp_tag", 32'(rtag_w[d][p]), 32'(rs.tag));
                end else begin
                    check_eq("resp_valid_idle", 32'(rv_w[d]), 32'd0);
                end
            end
            if (iss_q.size() > 0 && iss_q[0].cyc == cyc) void'(iss_q.pop_front());
            if (g >= 0) begin
                r = req_q[g][0];
                is.cyc = cyc + 1; is.we = r.we; is.a = r.a; is.wd = r.wd;
                iss_q.push_back(is);
                if (r.we) mmem[r.a] = r.wd;
                for (int d = 0; d < 2; d++) begin
                    if (!r.we || d == 1) begin
                        rs.due  = cyc + 2 + lat_of(d);
                        rs.port = g;
                        rs.data = r.we ? 16'h0000 : mmem[r.a];
                        rs.tag  = r.t;
                        rsp_q[d].push_back(rs);
                    end
                end
                ptr_m  = (g + 1) % 3;
                acc[g] = 1'b1;
            end
        end
        cyc++;
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; ptr_m = 0; acc = '0;
        vld = '0; we = '0;
        for (int p = 0; p < 3; p++) begin
            addr[p] = '0; wdata[p] = '0; tag[p] = '0;
        end
        for (int i = 0; i < 256; i++) mmem[i] = init_word(i);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_bank_en", 32'(en_w[d]), 32'd0);
            check_eq("rst_bank_addr", 32'(baddr_w[d]), 32'd0);
            check_eq("rst_bank_wdata", 32'(bwdata_w[d]), 32'd0);
            check_eq("rst_resp_valid", 32'(rv_w[d]), 32'd0);
            for (int p = 0; p < 3; p++) begin
                check_eq("rst_resp_data", 32'(rdat_w[d][p]), 32'd0);
                check_eq("rst_resp_tag", 32'(rtag_w[d][p]), 32'd0);
            end
        end
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // p2 write then read-back of the same address
        push_req(1, 1'b1, 8'h10, 16'hBEEF, 2'b01);
        push_req(1, 1'b0, 8'h10, 16'h0000, 2'b10);
        wait_drain();

        // all ports streaming reads
        for (int i = 0; i < 6; i++)
            for (int p = 0; p < 3; p++)
                push_req(p, 1'b0, 8'(8'h20 + 8'(i * 3 + p)), 16'h0000, 2'(i + p));
        wait_drain();

        // read in flight killed by a one-cycle reset
        push_req(0, 1'b0, 8'h10, 16'h0000, 2'b11);
        for (int i = 0; i < 20 && req_q[0].size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        // pointer back at port 1: p1 must beat p2
        push_req(1, 1'b0, 8'h31, 16'h0000, 2'b01);
        push_req(0, 1'b0, 8'h30, 16'h0000, 2'b00);
        wait_drain();

        // p3 alone moves the pointer to port 1, then p3 alone again, then all three
        push_req(2, 1'b0, 8'h40, 16'h0000, 2'b10);
        wait_drain();
        push_req(2, 1'b0, 8'h41, 16'h0000, 2'b11);
        wait_drain();
        for (int p = 0; p < 3; p++) push_req(p, 1'b0, 8'(8'h50 + 8'(p)), 16'h0000, 2'(p));
        wait_drain();

        // back-to-back p1 write and read
        push_req(0, 1'b1, 8'h22, 16'h1234, 2'b01);
        push_req(0, 1'b0, 8'h22, 16'h0000, 2'b10);
        wait_drain();
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
